// File: rtl/fir_frame_pack_pkg.sv
// rtl/fir_frame_pack_pkg.sv - shared types and field layout for the FIR frame packer
package fir_frame_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY
    } state_t;

    localparam int SEQ_WD  = 32;
    localparam int DROP_WD = 16;

    // Sequence number sits directly above the encoder word in the header beat.
    function automatic int seq_lsb(input int head_wd);
        return head_wd;
    endfunction

endpackage

// File: rtl/fir_frame_pack_if.sv
// rtl/fir_frame_pack_if.sv - framed valid/ready output stream of the FIR frame packer
interface fir_frame_pack_if #(
    parameter int DATA_WD = 512
);
    logic               m_valid;
    logic               m_ready;
    logic [DATA_WD-1:0] m_data;
    logic               m_user;
    logic               m_last;

    modport master (
        output m_valid,
        input  m_ready,
        output m_data,
        output m_user,
        output m_last
    );

    modport slave (
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_user,
        input  m_last
    );
endinterface

// File: rtl/fir_frame_pack_fifo.sv
// rtl/fir_frame_pack_fifo.sv - first-word-fall-through FIFO with synchronous flush
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fir_frame_pack.sv
// rtl/fir_frame_pack.sv - buffers aligned FIR beats and emits header + data framed stream
module fir_frame_pack
    import fir_frame_pack_pkg::*;
#(
    parameter int DATA_WD    = 512,
    parameter int HEAD_WD    = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WD     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_rst,
    input  logic [LEN_WD-1:0]   frame_len,
    input  logic                fir_ivld,
    input  logic [DATA_WD-1:0]  fir_idat,
    input  logic [HEAD_WD-1:0]  enc_idat,
    fir_frame_pack_if.master    m,
    output logic                ovf_flag,
    output logic [DROP_WD-1:0]  drop_cnt
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int SEQ_LSB = seq_lsb(HEAD_WD);

    logic [HEAD_WD+DATA_WD-1:0] fifo_rd;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [AW:0]                fifo_count;
    logic                       fifo_pop;

    state_t              state_q, state_d;
    logic [LEN_WD-1:0]   len_q, len_d, len_eff;
    logic [LEN_WD-1:0]   beat_cnt_q;
    logic [SEQ_WD-1:0]   frame_seq_q;
    logic                can_load;
    logic                hdr_load;
    logic                dat_load;
    logic                last_d;
    logic                drop;
    logic [DATA_WD-1:0]  hdr_word;

    sync_fifo_fwft #(
        .WIDTH (HEAD_WD + DATA_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (cfg_rst),
        .wr_en   (fir_ivld),
        .wr_data ({enc_idat, fir_idat}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign can_load = !m.m_valid || m.m_ready;
    assign len_eff  = (frame_len == '0) ? LEN_WD'(1) : frame_len;
    assign drop     = fir_ivld && fifo_full;

    always_comb begin
        hdr_word                          = '0;
        hdr_word[HEAD_WD-1:0]             = fifo_rd[DATA_WD +: HEAD_WD];
        hdr_word[SEQ_LSB +: SEQ_WD]       = frame_seq_q;
    end

    // IDLE loads the header straight away when it can, so a lone beat costs one cycle of latency.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        hdr_load = 1'b0;
        dat_load = 1'b0;
        last_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    len_d = len_eff;
                    if (can_load) begin
                        hdr_load = 1'b1;
                        state_d  = ST_BODY;
                    end else begin
                        state_d  = ST_HEAD;
                    end
                end
            end
            ST_HEAD: begin
                if (can_load) begin
                    hdr_load = 1'b1;
                    state_d  = ST_BODY;
                end
            end
            ST_BODY: begin
                if (!fifo_empty && can_load) begin
                    dat_load = 1'b1;
                    fifo_pop = 1'b1;
                    if (beat_cnt_q == len_q - LEN_WD'(1)) begin
                        last_d = 1'b1;
                        if (fifo_count > CW'(1)) begin
                            state_d = ST_HEAD;
                            len_d   = len_eff;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= LEN_WD'(1);
            beat_cnt_q  <= '0;
            frame_seq_q <= '0;
            ovf_flag    <= 1'b0;
            drop_cnt    <= '0;
            m.m_valid   <= 1'b0;
            m.m_data    <= '0;
            m.m_user    <= 1'b0;
            m.m_last    <= 1'b0;
        end else if (cfg_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= LEN_WD'(1);
            beat_cnt_q  <= '0;
            frame_seq_q <= '0;
            ovf_flag    <= 1'b0;
            drop_cnt    <= '0;
            m.m_valid   <= 1'b0;
            m.m_data    <= '0;
            m.m_user    <= 1'b0;
            m.m_last    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            if (drop) begin
                ovf_flag <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
            if (dat_load) begin
                beat_cnt_q <= last_d ? '0 : beat_cnt_q + 1'b1;
                if (last_d) frame_seq_q <= frame_seq_q + 1'b1;
            end
            if (hdr_load || dat_load) begin
                m.m_valid <= 1'b1;
                m.m_data  <= hdr_load ? hdr_word : fifo_rd[DATA_WD-1:0];
                m.m_user  <= hdr_load;
                m.m_last  <= last_d;
            end else if (can_load) begin
                m.m_valid <= 1'b0;
            end
        end
    end
endmodule
